// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: ALU opcodes, result selects, forward selects
// and the ID/EX control bundle.
package riscv_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        result_src_e result_src;
        alu_op_e     alu_cntrl;
    } id_ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational MEM/WB -> EX forward-select for both ALU sources.
// MEM wins over WB; x0 is never forwarded.
module fwd_unit
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output fwd_sel_e          fwd_a,
    output fwd_sel_e          fwd_b
);

    always_comb begin
        fwd_a = FWD_RF;
        if (rs1 != '0) begin
            if (mem_reg_write && (mem_rd == rs1))
                fwd_a = FWD_MEM;
            else if (wb_reg_write && (wb_rd == rs1))
                fwd_a = FWD_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (rs2 != '0) begin
            if (mem_reg_write && (mem_rd == rs2))
                fwd_b = FWD_MEM;
            else if (wb_reg_write && (wb_rd == rs2))
                fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, branch-target adder and
// load-use hazard detection; supports stall (hold) and flush (bubble).
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [WIDTH-1:0]  id_rd1,
    input  logic [WIDTH-1:0]  id_rd2,
    input  logic [WIDTH-1:0]  id_imm_ext,
    input  logic [WIDTH-1:0]  id_pc,
    input  logic [WIDTH-1:0]  id_pc_plus4,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_write,
    input  logic              id_jump,
    input  logic              id_branch,
    input  logic              id_alu_src,
    input  logic [1:0]        id_result_src,
    input  logic [2:0]        id_alu_cntrl,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [WIDTH-1:0]  mem_alu_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [WIDTH-1:0]  wb_result,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_src_a,
    output logic [WIDTH-1:0]  ex_src_b,
    output logic [2:0]        ex_alu_cntrl,
    output logic [WIDTH-1:0]  ex_write_data,
    output logic [WIDTH-1:0]  ex_pc_target,
    output logic [WIDTH-1:0]  ex_pc_plus4,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_write,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic [1:0]        ex_result_src,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use_hazard
);

    logic              valid_q;
    logic [WIDTH-1:0]  rd1_q, rd2_q, imm_q, pc_q, pc4_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    id_ex_ctrl_t       ctrl_q;
    fwd_sel_e          fwd_a_s, fwd_b_s;
    logic [WIDTH-1:0]  fwd_rs2;

    // A non-valid ID slot is captured as a bubble so that an empty EX
    // always presents zero data and no enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (flush || (!stall && !id_valid)) begin
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (!stall) begin
            valid_q              <= 1'b1;
            rd1_q                <= id_rd1;
            rd2_q                <= id_rd2;
            imm_q                <= id_imm_ext;
            pc_q                 <= id_pc;
            pc4_q                <= id_pc_plus4;
            rs1_q                <= id_rs1;
            rs2_q                <= id_rs2;
            rd_q                 <= id_rd;
            ctrl_q.reg_write     <= id_reg_write;
            ctrl_q.mem_write     <= id_mem_write;
            ctrl_q.jump          <= id_jump;
            ctrl_q.branch        <= id_branch;
            ctrl_q.alu_src       <= id_alu_src;
            ctrl_q.result_src    <= result_src_e'(id_result_src);
            ctrl_q.alu_cntrl     <= alu_op_e'(id_alu_cntrl);
        end
    end

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .rs1           (rs1_q),
        .rs2           (rs2_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a_s),
        .fwd_b         (fwd_b_s)
    );

    always_comb begin
        unique case (fwd_a_s)
            FWD_MEM: ex_src_a = mem_alu_result;
            FWD_WB:  ex_src_a = wb_result;
            default: ex_src_a = rd1_q;
        endcase
    end

    always_comb begin
        unique case (fwd_b_s)
            FWD_MEM: fwd_rs2 = mem_alu_result;
            FWD_WB:  fwd_rs2 = wb_result;
            default: fwd_rs2 = rd2_q;
        endcase
    end

    assign ex_src_b      = ctrl_q.alu_src ? imm_q : fwd_rs2;
    assign ex_write_data = fwd_rs2;
    assign ex_pc_target  = pc_q + imm_q;
    assign ex_pc_plus4   = pc4_q;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_jump       = ctrl_q.jump;
    assign ex_branch     = ctrl_q.branch;
    assign ex_result_src = ctrl_q.result_src;
    assign ex_alu_cntrl  = ctrl_q.alu_cntrl;
    assign fwd_a         = fwd_a_s;
    assign fwd_b         = fwd_b_s;

    assign load_use_hazard = valid_q && (ctrl_q.result_src == RES_LOAD) && (rd_q != '0)
                             && ((rd_q == id_rs1) || (rd_q == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: per-cycle model comparison plus
// directed literal checks of forwarding, hazard, stall/flush and reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm_ext, id_pc, id_pc_plus4;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_write, id_jump, id_branch, id_alu_src;
    logic [1:0]  id_result_src;
    logic [2:0]  id_alu_cntrl;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_alu_result, wb_result;

    logic        ex_valid;
    logic [31:0] ex_src_a, ex_src_b, ex_write_data, ex_pc_target, ex_pc_plus4;
    logic [2:0]  ex_alu_cntrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_write, ex_jump, ex_branch;
    logic [1:0]  ex_result_src, fwd_a, fwd_b;
    logic        load_use_hazard;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm_ext(id_imm_ext), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_jump(id_jump),
        .id_branch(id_branch), .id_alu_src(id_alu_src), .id_result_src(id_result_src),
        .id_alu_cntrl(id_alu_cntrl), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_alu_result(mem_alu_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_result(wb_result), .ex_valid(ex_valid), .ex_src_a(ex_src_a),
        .ex_src_b(ex_src_b), .ex_alu_cntrl(ex_alu_cntrl), .ex_write_data(ex_write_data),
        .ex_pc_target(ex_pc_target), .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_jump(ex_jump),
        .ex_branch(ex_branch), .ex_result_src(ex_result_src), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of what EX holds: the instruction ID offered at the last capturing edge.
    logic        m_valid;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        m_rw, m_mw, m_j, m_b, m_as;
    logic [1:0]  m_rsrc;
    logic [2:0]  m_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush || (!stall && !id_valid)) begin
            m_valid <= 0; m_rd1 <= 0; m_rd2 <= 0; m_imm <= 0; m_pc <= 0; m_pc4 <= 0;
            m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_rw <= 0; m_mw <= 0; m_j <= 0;
            m_b <= 0; m_as <= 0; m_rsrc <= 0; m_op <= 0;
        end else if (!stall) begin
            m_valid <= 1; m_rd1 <= id_rd1; m_rd2 <= id_rd2; m_imm <= id_imm_ext;
            m_pc <= id_pc; m_pc4 <= id_pc_plus4; m_rs1 <= id_rs1; m_rs2 <= id_rs2;
            m_rd <= id_rd; m_rw <= id_reg_write; m_mw <= id_mem_write; m_j <= id_jump;
            m_b <= id_branch; m_as <= id_alu_src; m_rsrc <= id_result_src;
            m_op <= id_alu_cntrl;
        end
    end

    function automatic logic [1:0] exp_sel(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (mem_reg_write && mem_rd == rs) return 2'd2;
        if (wb_reg_write && wb_rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    // Newest in-flight value of register rs, falling back to the regfile read.
    function automatic logic [31:0] reg_value(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return rf;
        if (mem_reg_write && mem_rd == rs) return mem_alu_result;
        if (wb_reg_write && wb_rd == rs) return wb_result;
        return rf;
    endfunction

    always @(negedge clk) begin
        chk("valid",      {31'b0, ex_valid},       {31'b0, m_valid});
        chk("src_a",      ex_src_a,                reg_value(m_rs1, m_rd1));
        chk("src_b",      ex_src_b,                m_as ? m_imm : reg_value(m_rs2, m_rd2));
        chk("write_data", ex_write_data,           reg_value(m_rs2, m_rd2));
        chk("pc_target",  ex_pc_target,            m_pc + m_imm);
        chk("pc_plus4",   ex_pc_plus4,             m_pc4);
        chk("alu_cntrl",  {29'b0, ex_alu_cntrl},   {29'b0, m_op});
        chk("rd",         {27'b0, ex_rd},          {27'b0, m_rd});
        chk("ctrl",       {27'b0, ex_reg_write, ex_mem_write, ex_jump, ex_branch, ex_result_src[0]},
                          {27'b0, m_rw, m_mw, m_j, m_b, m_rsrc[0]});
        chk("result_src", {30'b0, ex_result_src},  {30'b0, m_rsrc});
        chk("fwd_a",      {30'b0, fwd_a},          {30'b0, exp_sel(m_rs1)});
        chk("fwd_b",      {30'b0, fwd_b},          {30'b0, exp_sel(m_rs2)});
        chk("load_use",   {31'b0, load_use_hazard},
            {31'b0, m_valid && m_rsrc == 2'b01 && m_rd != 0 && (m_rd == id_rs1 || m_rd == id_rs2)});
    end

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic rw,
                          input logic mw, input logic j, input logic b, input logic as,
                          input logic [1:0] rsrc, input logic [2:0] op);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd1 = rd1; id_rd2 = rd2;
        id_imm_ext = imm; id_pc = pc; id_pc_plus4 = pc + 32'd4; id_reg_write = rw;
        id_mem_write = mw; id_jump = j; id_branch = b; id_alu_src = as;
        id_result_src = rsrc; id_alu_cntrl = op;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        mem_rd = 0; mem_reg_write = 0; mem_alu_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
        #1;
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_fwd",   {28'b0, fwd_a, fwd_b}, 32'd0);
        chk("rst_lu",    {31'b0, load_use_hazard}, 32'd0);
        next_cycle();
        rst_n = 1;

        // add x3,x1,x2 with x1 pending in both MEM and WB: MEM wins
        set_id(1, 5'd1, 5'd2, 5'd3, 32'h111, 32'h222, 0, 32'h100, 1, 0, 0, 0, 0, 2'b00, 3'b000);
        mem_rd = 1; mem_reg_write = 1; mem_alu_result = 32'h10;
        wb_rd = 1; wb_reg_write = 1; wb_result = 32'h20;
        next_cycle(); #1;
        chk("add_fwd_a", {30'b0, fwd_a}, 32'd2);
        chk("add_src_a", ex_src_a, 32'h10);
        chk("add_src_b", ex_src_b, 32'h222);
        chk("add_rd",    {27'b0, ex_rd}, 32'd3);

        // rs2 = x0 with MEM "writing" x0: no forward; rs1 from WB
        set_id(1, 5'd2, 5'd0, 5'd4, 32'h5, 32'hABCD, 0, 32'h104, 1, 0, 0, 0, 0, 2'b00, 3'b001);
        mem_rd = 0; mem_reg_write = 1; wb_rd = 2;
        next_cycle(); #1;
        chk("x0_fwd_b", {30'b0, fwd_b}, 32'd0);
        chk("x0_src_b", ex_src_b, 32'hABCD);
        chk("wb_fwd_a", {30'b0, fwd_a}, 32'd1);
        chk("wb_src_a", ex_src_a, 32'h20);

        // PC-target wraparound, immediate operand, branch control
        set_id(1, 5'd7, 5'd8, 5'd0, 32'd100, 32'd200, 32'd8, 32'hFFFF_FFFC, 0, 0, 0, 1, 1, 2'b00, 3'b001);
        mem_reg_write = 0; wb_reg_write = 0;
        next_cycle(); #1;
        chk("wrap_target", ex_pc_target, 32'h0000_0004);
        chk("wrap_pc4",    ex_pc_plus4, 32'h0000_0000);
        chk("imm_src_b",   ex_src_b, 32'd8);
        chk("store_data",  ex_write_data, 32'd200);

        // sw / jal-like controls pass through
        set_id(1, 5'd9, 5'd10, 5'd0, 32'h1, 32'hDEAD, 32'h10, 32'h200, 0, 1, 0, 0, 1, 2'b00, 3'b000);
        next_cycle();
        set_id(1, 5'd0, 5'd0, 5'd1, 0, 0, 32'h40, 32'h300, 1, 0, 1, 0, 0, 2'b10, 3'b101);
        next_cycle(); #1;
        chk("jal_ctrl", {30'b0, ex_jump, ex_result_src[1]}, 32'd3);

        // lw x5 in EX, ID reads x5 -> hazard; then stall+flush together -> bubble
        set_id(1, 5'd1, 5'd0, 5'd5, 32'h1000, 0, 32'd4, 32'h400, 1, 0, 0, 0, 1, 2'b01, 3'b000);
        next_cycle();
        set_id(1, 5'd6, 5'd5, 5'd7, 0, 0, 0, 32'h404, 1, 0, 0, 0, 0, 2'b00, 3'b000);
        #1;
        chk("lu_hit", {31'b0, load_use_hazard}, 32'd1);
        id_rs2 = 5'd7; #1;
        chk("lu_miss", {31'b0, load_use_hazard}, 32'd0);
        id_rs2 = 5'd5;
        stall = 1; flush = 1;
        next_cycle(); #1;
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_rw",    {31'b0, ex_reg_write}, 32'd0);
        stall = 0; flush = 0;

        // capture, then hold 3 cycles while ID changes and MEM forwarding moves
        set_id(1, 5'd1, 5'd2, 5'd10, 32'h11, 32'h22, 32'h55, 32'h500, 1, 0, 0, 0, 1, 2'b00, 3'b011);
        next_cycle();
        stall = 1;
        mem_rd = 1; mem_reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'd3, 5'd4, 5'(11 + i), 32'(i), 32'(i), 32'(i), 32'h600, 0, 0, 0, 0, 0, 2'b00, 3'b010);
            mem_alu_result = 32'h1000 * 32'(i) + 32'd7;
            next_cycle(); #1;
            chk("stall_rd",    {27'b0, ex_rd}, 32'd10);
            chk("stall_op",    {29'b0, ex_alu_cntrl}, 32'd3);
            chk("stall_imm",   ex_src_b, 32'h55);
            chk("stall_fwd_a", ex_src_a, 32'h1000 * 32'(i) + 32'd7);
        end
        stall = 0; mem_reg_write = 0;

        // non-valid ID slot becomes an empty EX
        set_id(0, 5'd3, 5'd4, 5'd12, 32'h77, 32'h88, 32'h9, 32'h700, 1, 1, 1, 1, 1, 2'b01, 3'b001);
        next_cycle(); #1;
        chk("idle_valid", {31'b0, ex_valid}, 32'd0);
        chk("idle_src_b", ex_src_b, 32'd0);

        // asynchronous reset mid-run with a register-writing instruction in EX
        set_id(1, 5'd8, 5'd9, 5'd13, 32'h99, 32'hAA, 32'h4, 32'h800, 1, 0, 0, 0, 0, 2'b00, 3'b000);
        next_cycle(); #1;
        chk("pre_rst_rw", {31'b0, ex_reg_write}, 32'd1);
        rst_n = 0; #1;
        chk("arst_valid", {31'b0, ex_valid}, 32'd0);
        chk("arst_rw",    {31'b0, ex_reg_write}, 32'd0);
        chk("arst_rd",    {27'b0, ex_rd}, 32'd0);
        chk("arst_src_a", ex_src_a, 32'd0);
        chk("arst_pc4",   ex_pc_plus4, 32'd0);
        next_cycle();
        rst_n = 1;
        set_id(1, 5'd14, 5'd15, 5'd16, 32'hBEEF, 32'hCAFE, 32'h0, 32'h900, 1, 0, 0, 0, 0, 2'b00, 3'b010);
        next_cycle(); #1;
        chk("post_rst_rd",  {27'b0, ex_rd}, 32'd16);
        chk("post_rst_src", ex_src_a, 32'hBEEF);

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
